// File: rtl/linebuffer_ctrl.sv
// linebuffer_ctrl
//   Scheduler for the ping-pong scanline buffer pair. Every line_start toggles
//   the buffer select, then clears the new draw buffer one 256-bit tile word
//   per cycle. After clearing, it grants the draw ports to the line renderer
//   and tracks whether the renderer finishes before the next swap.
//
//   Optional feature: define LBCTRL_OVERRUN_CNT_EN to add a saturating 16-bit
//   overrun event counter output (overrun_cnt).
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   line_start, next_line      swap pulse from VGA timing and the line drawn after it
//   disp_x                     display x, forwarded to addr_pixel_disp
//   switch                     buffer select to the linebuffer pair
//   addr/wren_pixel_disp       display pixel port (never written)
//   addr/data/wren_tile_draw   draw tile port (controller in CLEAR, renderer in DRAW)
//   addr/data/wren_pixel_draw  draw pixel port (renderer in DRAW only)
//   r_*_tile, r_*_pixel        renderer requests for the draw ports
//   draw_start/draw_line       renderer kick-off pulse and line number
//   draw_abort, draw_done      renderer abort pulse / completion input
//   busy, overrun              activity flag, sticky overrun flag
module linebuffer_ctrl #(
    parameter int          NUM_TILES   = 40,
    parameter logic [15:0] CLEAR_COLOR = 16'h0000,
    parameter int          LINE_W      = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_start,
    input  logic [LINE_W-1:0] next_line,
    input  logic [9:0]        disp_x,
    output logic              switch,
    output logic [9:0]        addr_pixel_disp,
    output logic              wren_pixel_disp,
    output logic [5:0]        addr_tile_draw,
    output logic [255:0]      data_tile_draw,
    output logic              wren_tile_draw,
    output logic [9:0]        addr_pixel_draw,
    output logic [15:0]       data_pixel_draw,
    output logic              wren_pixel_draw,
    input  logic [5:0]        r_addr_tile,
    input  logic [255:0]      r_data_tile,
    input  logic              r_wren_tile,
    input  logic [9:0]        r_addr_pixel,
    input  logic [15:0]       r_data_pixel,
    input  logic              r_wren_pixel,
    output logic              draw_start,
    output logic [LINE_W-1:0] draw_line,
    output logic              draw_abort,
    input  logic              draw_done,
    output logic              busy,
    output logic              overrun
`ifdef LBCTRL_OVERRUN_CNT_EN
    ,
    output logic [15:0]       overrun_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DRAW, S_DONE} state_t;

    localparam logic [5:0] LAST_TILE = 6'(NUM_TILES - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_overrun_evt;
    logic [5:0]        r_clr_ptr;
    logic              r_switch;
    logic [LINE_W-1:0] r_draw_line;
    logic              r_draw_start;
    logic              r_draw_abort;
    logic              r_overrun;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state    = r_state;
        w_overrun_evt   = 1'b0;
        addr_tile_draw  = '0;
        data_tile_draw  = '0;
        wren_tile_draw  = 1'b0;
        addr_pixel_draw = '0;
        data_pixel_draw = '0;
        wren_pixel_draw = 1'b0;
        case (r_state)
            S_CLEAR: begin
                addr_tile_draw = r_clr_ptr;
                data_tile_draw = {16{CLEAR_COLOR}};
                wren_tile_draw = 1'b1;
                if (r_clr_ptr == LAST_TILE) w_next_state = S_DRAW;
            end
            S_DRAW: begin
                addr_tile_draw  = r_addr_tile;
                data_tile_draw  = r_data_tile;
                wren_tile_draw  = r_wren_tile;
                addr_pixel_draw = r_addr_pixel;
                data_pixel_draw = r_data_pixel;
                wren_pixel_draw = r_wren_pixel;
                if (draw_done) w_next_state = S_DONE;
            end
            default: ;
        endcase
        // A swap always restarts the clear. A draw_done arriving together
        // with the swap in DRAW counts as an on-time finish.
        if (line_start) begin
            w_next_state  = S_CLEAR;
            w_overrun_evt = (r_state == S_CLEAR) || ((r_state == S_DRAW) && !draw_done);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_switch     <= 1'b0;
            r_draw_line  <= '0;
            r_clr_ptr    <= '0;
            r_draw_start <= 1'b0;
            r_draw_abort <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            // Abort is registered so it lines up with the new switch value.
            r_draw_abort <= w_overrun_evt;
            r_draw_start <= (r_state == S_CLEAR) && (r_clr_ptr == LAST_TILE) && !line_start;
            if (w_overrun_evt) r_overrun <= 1'b1;
            if (line_start) begin
                r_switch    <= ~r_switch;
                r_draw_line <= next_line;
                r_clr_ptr   <= '0;
            end else if (r_state == S_CLEAR) begin
                r_clr_ptr   <= r_clr_ptr + 6'd1;
            end
        end
    end

`ifdef LBCTRL_OVERRUN_CNT_EN
    logic [15:0] r_overrun_cnt;
    always_ff @(posedge clk) begin
        if (reset)                                        r_overrun_cnt <= '0;
        else if (w_overrun_evt && (r_overrun_cnt != 16'hFFFF)) r_overrun_cnt <= r_overrun_cnt + 16'd1;
    end
    assign overrun_cnt = r_overrun_cnt;
`endif

    assign switch          = r_switch;
    assign draw_line       = r_draw_line;
    assign draw_start      = r_draw_start;
    assign draw_abort      = r_draw_abort;
    assign overrun         = r_overrun;
    assign busy            = (r_state == S_CLEAR) || (r_state == S_DRAW);
    assign addr_pixel_disp = disp_x;
    assign wren_pixel_disp = 1'b0;

endmodule

// File: tb/tb_linebuffer_ctrl.sv
module tb_linebuffer_ctrl;
    localparam int NT = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1, line_start = 1'b0, draw_done = 1'b0;
    logic [9:0]   next_line = '0, disp_x = '0;
    logic         switch, wren_pixel_disp, wren_tile_draw, wren_pixel_draw;
    logic [9:0]   addr_pixel_disp, addr_pixel_draw, draw_line;
    logic [5:0]   addr_tile_draw;
    logic [255:0] data_tile_draw;
    logic [15:0]  data_pixel_draw;
    logic [5:0]   r_addr_tile = '0;
    logic [255:0] r_data_tile = '0;
    logic         r_wren_tile = 1'b0, r_wren_pixel = 1'b0;
    logic [9:0]   r_addr_pixel = '0;
    logic [15:0]  r_data_pixel = '0;
    logic         draw_start, draw_abort, busy, overrun;
`ifdef LBCTRL_OVERRUN_CNT_EN
    logic [15:0]  overrun_cnt;
`endif

    linebuffer_ctrl dut (
        .clk(clk), .reset(reset), .line_start(line_start), .next_line(next_line),
        .disp_x(disp_x), .switch(switch), .addr_pixel_disp(addr_pixel_disp),
        .wren_pixel_disp(wren_pixel_disp), .addr_tile_draw(addr_tile_draw),
        .data_tile_draw(data_tile_draw), .wren_tile_draw(wren_tile_draw),
        .addr_pixel_draw(addr_pixel_draw), .data_pixel_draw(data_pixel_draw),
        .wren_pixel_draw(wren_pixel_draw), .r_addr_tile(r_addr_tile),
        .r_data_tile(r_data_tile), .r_wren_tile(r_wren_tile),
        .r_addr_pixel(r_addr_pixel), .r_data_pixel(r_data_pixel),
        .r_wren_pixel(r_wren_pixel), .draw_start(draw_start), .draw_line(draw_line),
        .draw_abort(draw_abort), .draw_done(draw_done), .busy(busy), .overrun(overrun)
`ifdef LBCTRL_OVERRUN_CNT_EN
        , .overrun_cnt(overrun_cnt)
`endif
    );

    int checks = 0, failures = 0;

    // Reference model: time elapsed since the last swap decides the activity.
    // m_since = 0 : no line since reset; 1..NT : clearing tile m_since-1;
    // > NT : drawing until the renderer reports done.
    int       m_since = 0, m_cnt = 0;
    bit       m_done = 0, m_sw = 0, m_abort = 0, m_ovr = 0;
    bit [9:0] m_dl = '0;

    function automatic bit m_clearing();
        return (m_since >= 1) && (m_since <= NT);
    endfunction
    function automatic bit m_drawing();
        return (m_since > NT) && !m_done;
    endfunction

    function automatic void model_update();
        bit ev;
        if (reset) begin
            m_since = 0; m_done = 0; m_sw = 0; m_abort = 0; m_ovr = 0; m_dl = '0; m_cnt = 0;
        end else if (line_start) begin
            ev = m_clearing() || (m_drawing() && !draw_done);
            m_abort = ev;
            if (ev) begin
                m_ovr = 1;
                if (m_cnt < 65535) m_cnt++;
            end
            m_sw = !m_sw; m_dl = next_line; m_since = 1; m_done = 0;
        end else begin
            m_abort = 0;
            if (m_drawing() && draw_done) m_done = 1;
            if (m_since > 0 && m_since < 100000) m_since++;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if ({switch, wren_tile_draw, wren_pixel_draw, wren_pixel_disp, busy, overrun, draw_start, draw_abort} !== 8'b0) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d got sw/wt/wp/wd/busy/ovr/st/ab=%b expected 00000000", i,
                         {switch, wren_tile_draw, wren_pixel_draw, wren_pixel_disp, busy, overrun, draw_start, draw_abort});
            end
            tick();
        end
    endtask

    task automatic test_clear_draw();
        line_start = 1'b1; next_line = 10'd37;
        tick();
        line_start = 1'b0;
        #1;
        checks++;
        if (switch !== 1'b1) begin failures++; $display("FAIL swap_switch got=%b expected=1", switch); end
        for (int k = 0; k < NT; k++) begin
            if (k == 5) begin r_wren_pixel = 1'b1; r_addr_pixel = 10'd100; r_data_pixel = 16'hF800; end
            #1;
            checks++;
            if (wren_tile_draw !== 1'b1 || addr_tile_draw !== 6'(k) || data_tile_draw !== 256'd0 || draw_start !== 1'b0) begin
                failures++;
                $display("FAIL clear_write k=%0d got wren=%b addr=%0d data_nz=%b start=%b expected wren=1 addr=%0d data=0 start=0",
                         k, wren_tile_draw, addr_tile_draw, |data_tile_draw, draw_start, k);
            end
            if (k == 5) begin
                checks++;
                if (wren_pixel_draw !== 1'b0) begin failures++; $display("FAIL clear_gate_pixel got=%b expected=0", wren_pixel_draw); end
            end
            tick();
        end
        #1;
        checks++;
        if (draw_start !== 1'b1 || draw_line !== 10'd37) begin
            failures++; $display("FAIL draw_start got start=%b line=%0d expected start=1 line=37", draw_start, draw_line);
        end
        checks++;
        if (wren_pixel_draw !== 1'b1 || addr_pixel_draw !== 10'd100 || data_pixel_draw !== 16'hF800) begin
            failures++; $display("FAIL draw_pass got wren=%b addr=%0d data=%h expected 1 100 f800", wren_pixel_draw, addr_pixel_draw, data_pixel_draw);
        end
        disp_x = 10'd613;
        #1;
        checks++;
        if (addr_pixel_disp !== 10'd613 || wren_pixel_disp !== 1'b0) begin
            failures++; $display("FAIL disp_port got addr=%0d wren=%b expected 613 0", addr_pixel_disp, wren_pixel_disp);
        end
        tick();
        r_wren_pixel = 1'b0;
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || draw_start !== 1'b0) begin failures++; $display("FAIL done_idle got busy=%b start=%b expected 0 0", busy, draw_start); end
        line_start = 1'b1; next_line = 10'd38;
        tick();
        line_start = 1'b0;
        #1;
        checks++;
        if (draw_abort !== 1'b0 || overrun !== 1'b0 || switch !== 1'b0) begin
            failures++; $display("FAIL swap_after_done got abort=%b ovr=%b sw=%b expected 0 0 0", draw_abort, overrun, switch);
        end
    endtask

    task automatic test_done_and_swap();
        bit sw_before;
        for (int i = 0; i < NT + 3; i++) tick();
        sw_before = switch;
        line_start = 1'b1; draw_done = 1'b1;
        tick();
        line_start = 1'b0; draw_done = 1'b0;
        #1;
        checks++;
        if (draw_abort !== 1'b0 || overrun !== 1'b0 || switch !== !sw_before || busy !== 1'b1) begin
            failures++; $display("FAIL done_and_swap got abort=%b ovr=%b sw=%b busy=%b expected 0 0 %b 1", draw_abort, overrun, switch, busy, !sw_before);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < NT + 5; i++) tick();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        #1;
        checks++;
        if (draw_abort !== 1'b1 || overrun !== 1'b1 || addr_tile_draw !== 6'd0 || wren_tile_draw !== 1'b1) begin
            failures++; $display("FAIL overrun_draw got abort=%b ovr=%b addr=%0d wren=%b expected 1 1 0 1", draw_abort, overrun, addr_tile_draw, wren_tile_draw);
        end
`ifdef LBCTRL_OVERRUN_CNT_EN
        checks++;
        if (overrun_cnt !== 16'd1) begin failures++; $display("FAIL overrun_cnt1 got=%0d expected=1", overrun_cnt); end
`endif
        tick();
        #1;
        checks++;
        if (draw_abort !== 1'b0 || overrun !== 1'b1) begin failures++; $display("FAIL abort_pulse got abort=%b ovr=%b expected 0 1", draw_abort, overrun); end
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        #1;
        checks++;
        if (draw_abort !== 1'b1) begin failures++; $display("FAIL overrun_clear got abort=%b expected=1", draw_abort); end
`ifdef LBCTRL_OVERRUN_CNT_EN
        checks++;
        if (overrun_cnt !== 16'd2) begin failures++; $display("FAIL overrun_cnt2 got=%0d expected=2", overrun_cnt); end
`endif
    endtask

    task automatic test_reset_midline();
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (switch !== 1'b0 || busy !== 1'b0 || draw_abort !== 1'b0 || wren_tile_draw !== 1'b0 || overrun !== 1'b0 || draw_line !== 10'd0) begin
            failures++; $display("FAIL reset_midline got sw=%b busy=%b abort=%b wren=%b ovr=%b line=%0d expected all 0",
                                 switch, busy, draw_abort, wren_tile_draw, overrun, draw_line);
        end
`ifdef LBCTRL_OVERRUN_CNT_EN
        checks++;
        if (overrun_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d expected=0", overrun_cnt); end
`endif
    endtask

    task automatic test_random();
        logic [7:0] exp_ctl, got_ctl;
        for (int c = 0; c < 4000; c++) begin
            reset        = ($urandom_range(0, 599) == 0);
            line_start   = ($urandom_range(0, 59) == 0);
            draw_done    = ($urandom_range(0, 14) == 0);
            next_line    = 10'($urandom);
            disp_x       = 10'($urandom);
            r_addr_tile  = 6'($urandom);
            r_data_tile  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            r_wren_tile  = 1'($urandom);
            r_addr_pixel = 10'($urandom);
            r_data_pixel = 16'($urandom);
            r_wren_pixel = 1'($urandom);
            #1;
            exp_ctl = {m_sw, m_clearing() || m_drawing(), m_ovr, m_since == NT + 1, m_abort,
                       m_clearing() || (m_drawing() && r_wren_tile), m_drawing() && r_wren_pixel, 1'b0};
            got_ctl = {switch, busy, overrun, draw_start, draw_abort, wren_tile_draw, wren_pixel_draw, wren_pixel_disp};
            checks++;
            if (got_ctl !== exp_ctl) begin
                failures++; $display("FAIL rnd_ctl c=%0d got sw/busy/ovr/st/ab/wt/wp/wd=%b expected %b", c, got_ctl, exp_ctl);
            end
            checks++;
            if (draw_line !== m_dl || addr_pixel_disp !== disp_x) begin
                failures++; $display("FAIL rnd_line c=%0d got line=%0d disp=%0d expected %0d %0d", c, draw_line, addr_pixel_disp, m_dl, disp_x);
            end
            if (m_clearing()) begin
                checks++;
                if (addr_tile_draw !== 6'(m_since - 1) || data_tile_draw !== 256'd0) begin
                    failures++; $display("FAIL rnd_clear c=%0d got addr=%0d expected %0d", c, addr_tile_draw, m_since - 1);
                end
            end
            if (m_drawing()) begin
                checks++;
                if (addr_tile_draw !== r_addr_tile || data_tile_draw !== r_data_tile ||
                    addr_pixel_draw !== r_addr_pixel || data_pixel_draw !== r_data_pixel) begin
                    failures++; $display("FAIL rnd_pass c=%0d got taddr=%0d paddr=%0d pdata=%h expected %0d %0d %h",
                                         c, addr_tile_draw, addr_pixel_draw, data_pixel_draw, r_addr_tile, r_addr_pixel, r_data_pixel);
                end
            end
`ifdef LBCTRL_OVERRUN_CNT_EN
            checks++;
            if (overrun_cnt !== 16'(m_cnt)) begin failures++; $display("FAIL rnd_cnt c=%0d got=%0d expected=%0d", c, overrun_cnt, m_cnt); end
`endif
            tick();
        end
        reset = 1'b0; line_start = 1'b0; draw_done = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clear_draw();
        test_done_and_swap();
        test_overrun();
        test_reset_midline();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
